tq_itq_sched: RTL and testbench

Macroblock-level scheduler for the inverse transform/quantisation datapath (tq_idct_dequant) in the H.264 encoder reconstruction loop. It accepts the 24 quantised 4x4 residual blocks of one macroblock (16 luma, then 8 chroma AC) over a valid/ready stream. It selects the per-block QP (luma or chroma), drives the shared combinational dequant+IDCT datapath from a registered stage, and returns reconstructed residuals in order with block index and end-of-macroblock markers.

---
 rtl/tq_itq_sched.sv | 184 ++++++++++++++++++
 tb/tb_tq_itq_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tq_itq_sched.sv
// ---------------------------------------------------------------------------
// tq_itq_sched
//   Macroblock scheduler for the shared inverse quantisation / IDCT datapath.
//   It accepts the 24 quantised 4x4 blocks of one macroblock (16 luma, then
//   8 chroma AC) and picks the luma or chroma QP for each block. A registered
//   stage 1 (S1) drives the combinational datapath. Stage 2 (S2) captures the
//   datapath result. Residuals are returned in order, with the block index and
//   end-of-macroblock markers.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   mb_start_i             opens a macroblock (honoured only in IDLE)
//   qp_y_i, qp_c_i         luma / chroma QP, latched on an honoured start
//   in_valid_i/in_ready_o  input block handshake, in_coef_i = 16 x 15-bit
//   dp_coef_o, dp_qp_o     block and QP presented to the datapath (from S1)
//   dp_res_i               datapath result, combinational from dp_*
//   out_valid_o/out_ready_i output residual handshake
//   out_res_o, out_idx_o   residual block and its index
//   out_last_o             marks block NUM_BLK-1
//   mb_done_o              one-cycle pulse after the last output handshake
//   busy_o                 high whenever not IDLE
//
// Configuration
//   TQ_ZERO_SKIP_EN: all-zero blocks bypass the datapath. dp_coef_o keeps its
//   previous value and S2 loads zeros. Output values and timing are unchanged.
// ---------------------------------------------------------------------------
module tq_itq_sched #(
  parameter int NUM_BLK  = 24,
  parameter int LUMA_BLK = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mb_start_i,
  input  logic [5:0]   qp_y_i,
  input  logic [5:0]   qp_c_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [239:0] in_coef_i,
  output logic [239:0] dp_coef_o,
  output logic [5:0]   dp_qp_o,
  input  logic [239:0] dp_res_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [239:0] out_res_o,
  output logic [4:0]   out_idx_o,
  output logic         out_last_o,
  output logic         mb_done_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [4:0]   acc_cnt;
  logic [5:0]   qp_y, qp_c;
  logic         mb_done;

  logic         s1_valid;
  logic [239:0] s1_coef;
  logic [4:0]   s1_idx;
  logic [5:0]   s1_qp;
  logic         s2_valid;
  logic [239:0] s2_res;
  logic [4:0]   s2_idx;

  logic         s1_adv, s2_adv, accept, last_hs;

`ifdef TQ_ZERO_SKIP_EN
  logic         s1_zero;
  logic         in_zero;
  assign in_zero = (in_coef_i == 240'd0);
`endif

  // Pipeline moves whenever the stage ahead is empty or draining.
  assign s2_adv   = !s2_valid || out_ready_i;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready_o = (state == RUN) && (acc_cnt < 5'(NUM_BLK)) && s1_adv;
  assign accept   = in_valid_i && in_ready_o;
  assign last_hs  = s2_valid && out_ready_i && out_last_o;

  assign dp_coef_o   = s1_coef;
  assign dp_qp_o     = s1_qp;
  assign out_valid_o = s2_valid;
  assign out_res_o   = s2_res;
  assign out_idx_o   = s2_idx;
  assign out_last_o  = s2_valid && (s2_idx == 5'(NUM_BLK - 1));
  assign mb_done_o   = mb_done;
  assign busy_o      = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mb_start_i) state_nxt = RUN;
        else            state_nxt = IDLE;
      end
      RUN: begin
        if (accept && (acc_cnt == 5'(NUM_BLK - 1))) state_nxt = DRAIN;
        else                                        state_nxt = RUN;
      end
      DRAIN: begin
        if (last_hs) state_nxt = IDLE;
        else         state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Macroblock control: QP latch, acceptance counter, done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qp_y    <= 6'd0;
      qp_c    <= 6'd0;
      acc_cnt <= 5'd0;
      mb_done <= 1'b0;
    end else begin
      mb_done <= (state == DRAIN) && last_hs;
      if ((state == IDLE) && mb_start_i) begin
        qp_y    <= qp_y_i;
        qp_c    <= qp_c_i;
        acc_cnt <= 5'd0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + 5'd1;
      end
    end
  end

  // Stage 1: accepted block, its index and QP; feeds the datapath.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_coef  <= 240'd0;
      s1_idx   <= 5'd0;
      s1_qp    <= 6'd0;
`ifdef TQ_ZERO_SKIP_EN
      s1_zero  <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx <= acc_cnt;
        s1_qp  <= (acc_cnt < 5'(LUMA_BLK)) ? qp_y : qp_c;
`ifdef TQ_ZERO_SKIP_EN
        s1_zero <= in_zero;
        // Zero blocks leave the datapath input untouched.
        if (!in_zero) s1_coef <= in_coef_i;
`else
        s1_coef <= in_coef_i;
`endif
      end
    end
  end

  // Stage 2: datapath result held until the output handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_res   <= 240'd0;
      s2_idx   <= 5'd0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
`ifdef TQ_ZERO_SKIP_EN
        s2_res <= s1_zero ? 240'd0 : dp_res_i;
`else
        s2_res <= dp_res_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tq_itq_sched.sv
// ---------------------------------------------------------------------------
// tb_tq_itq_sched
//   Scoreboard bench for tq_itq_sched. The bench supplies a simple datapath
//   model on dp_res_i. It pushes the expected residual, index and last flag
//   for every accepted block, then pops and compares them on each output
//   handshake. It also checks dp_qp_o/dp_coef_o, the latency, mb_done_o
//   timing, output stability under stall, and reset behaviour.
// ---------------------------------------------------------------------------
module tb_tq_itq_sched;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         mb_start_i = 1'b0;
  logic [5:0]   qp_y_i = 6'd0;
  logic [5:0]   qp_c_i = 6'd0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [239:0] in_coef_i = 240'd0;
  logic [239:0] dp_coef_o;
  logic [5:0]   dp_qp_o;
  logic [239:0] dp_res_i;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [239:0] out_res_o;
  logic [4:0]   out_idx_o;
  logic         out_last_o;
  logic         mb_done_o;
  logic         busy_o;

  tq_itq_sched #(.NUM_BLK(24), .LUMA_BLK(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mb_start_i(mb_start_i),
    .qp_y_i(qp_y_i), .qp_c_i(qp_c_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_coef_i(in_coef_i),
    .dp_coef_o(dp_coef_o), .dp_qp_o(dp_qp_o), .dp_res_i(dp_res_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_res_o(out_res_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o),
    .mb_done_o(mb_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in datapath: each level doubled plus QP, 15-bit wrap.
  function automatic logic [239:0] dp_model(input logic [239:0] c, input logic [5:0] q);
    logic [239:0] r;
    r = 240'd0;
    for (int i = 0; i < 16; i++)
      r[i*15 +: 15] = {c[i*15 +: 14], 1'b0} + {9'd0, q};
    return r;
  endfunction

  assign dp_res_i = dp_model(dp_coef_o, dp_qp_o);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard and model state
  logic [245:0] exp_q[$];
  int           acc_cyc_q[$];
  int           exp_idx = 0;
  logic [5:0]   exp_qy = 6'd0, exp_qc = 6'd0;
  logic [239:0] last_coef = 240'd0;
  logic         dp_pend = 1'b0;
  logic [5:0]   pend_qp;
  logic [239:0] pend_coef;
  logic         hold_vld = 1'b0;
  logic [244:0] hold_val;
  int           exp_done_cyc = -1;
  logic         lat_chk = 1'b0;

  // Monitor: sample away from the active edge; handshakes seen here occur at the next posedge.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      logic [5:0]   q;
      logic [239:0] res;
      logic [245:0] e;
      int           a;
      if (dp_pend) begin
        chk("dp_qp", 256'(dp_qp_o), 256'(pend_qp));
        chk("dp_coef", 256'(dp_coef_o), 256'(pend_coef));
        dp_pend = 1'b0;
      end
      if (hold_vld && out_valid_o)
        chk("hold", 256'({out_idx_o, out_res_o}), 256'(hold_val));
      hold_vld = out_valid_o && !out_ready_i;
      hold_val = {out_idx_o, out_res_o};
      if (mb_done_o || (cyc == exp_done_cyc))
        chk("mb_done", 256'(mb_done_o), 256'(cyc == exp_done_cyc));
      if (in_valid_i && !busy_o)
        chk("idle_ready", 256'(in_ready_o), 256'd0);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 256'(out_idx_o), 256'hFF);
        end else begin
          e = exp_q.pop_front();
          a = acc_cyc_q.pop_front();
          chk("out", 256'({out_last_o, out_idx_o, out_res_o}), 256'(e));
          if (lat_chk) chk("latency", 256'(cyc - a), 256'd2);
          if (e[245]) exp_done_cyc = cyc + 1;
        end
      end
      if (in_valid_i && in_ready_o) begin
        q = (exp_idx < 16) ? exp_qy : exp_qc;
`ifdef TQ_ZERO_SKIP_EN
        res = (in_coef_i == 240'd0) ? 240'd0 : dp_model(in_coef_i, q);
        if (in_coef_i != 240'd0) last_coef = in_coef_i;
`else
        res = dp_model(in_coef_i, q);
        last_coef = in_coef_i;
`endif
        exp_q.push_back({(exp_idx == 23), 5'(exp_idx), res});
        acc_cyc_q.push_back(cyc);
        pend_qp = q;
        pend_coef = last_coef;
        dp_pend = 1'b1;
        exp_idx++;
      end
    end
  end

  task automatic start_mb(input logic [5:0] qy, input logic [5:0] qc);
    mb_start_i = 1'b1; qp_y_i = qy; qp_c_i = qc;
    exp_qy = qy; exp_qc = qc; exp_idx = 0;
    @(posedge clk_i); #1;
    mb_start_i = 1'b0;
  endtask

  // Drives n blocks; block zero_at is all-zero, a stray start (qp_y=40) rides with block start_at.
  task automatic send_blocks(input int n, input int zero_at, input int start_at);
    logic [255:0] rnd;
    logic         got;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      in_coef_i  = (k == zero_at) ? 240'd0 : (rnd[239:0] | 240'd1);
      in_valid_i = 1'b1;
      if (k == start_at) begin
        mb_start_i = 1'b1; qp_y_i = 6'd40;
      end
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk_i);
        got = in_ready_o;
        @(posedge clk_i); #1;
        mb_start_i = 1'b0;
      end
      if (!got) begin
        chk("accept_timeout", 256'd0, 256'd1);
        in_valid_i = 1'b0;
        return;
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk_i);
      seen = mb_done_o;
    end
    if (!seen) chk("done_timeout", 256'd0, 256'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 256'(in_ready_o), 256'd0);
    chk("rst_out_valid", 256'(out_valid_o), 256'd0);
    chk("rst_flags", 256'({mb_done_o, busy_o, out_last_o}), 256'd0);
    chk("rst_out_idx", 256'(out_idx_o), 256'd0);
    chk("rst_out_res", 256'(out_res_o), 256'd0);
    chk("rst_dp_coef", 256'(dp_coef_o), 256'd0);
    chk("rst_dp_qp", 256'(dp_qp_o), 256'd0);
  endtask

  initial begin
    #3;
    chk_reset_outputs();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // in_valid in IDLE must not be accepted (monitor checks in_ready)
    in_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 in_valid_i = 1'b0;

    // MB0: back-to-back, zero block at idx 5, latency checked
    lat_chk = 1'b1;
    start_mb(6'd28, 6'd30);
    chk("busy_run", 256'(busy_o), 256'd1);
    send_blocks(24, 5, -1);
    wait_done();
    lat_chk = 1'b0;
    chk("sb_empty_mb0", 256'(exp_q.size()), 256'd0);

    // MB1 starts in the mb_done cycle; stray start at block 3; stall mid-MB
    mb_start_i = 1'b1; qp_y_i = 6'd28; qp_c_i = 6'd30;
    exp_qy = 6'd28; exp_qc = 6'd30; exp_idx = 0;
    @(posedge clk_i); #1;
    mb_start_i = 1'b0;
    chk("busy_restart", 256'(busy_o), 256'd1);
    fork
      send_blocks(24, -1, 3);
      begin
        for (int t = 0; t < 500 && exp_idx < 8; t++) @(negedge clk_i);
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("stall_in_ready", 256'(in_ready_o), 256'd0);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
      end
    join
    wait_done();
    chk("sb_empty_mb1", 256'(exp_q.size()), 256'd0);

    // MB2: reset right after block 10 is accepted
    start_mb(6'd28, 6'd30);
    send_blocks(11, -1, -1);
    #1 rst_i = 1'b1;
    #1 chk_reset_outputs();
    exp_q.delete();
    acc_cyc_q.delete();
    exp_idx = 0; last_coef = 240'd0; dp_pend = 1'b0;
    hold_vld = 1'b0; exp_done_cyc = -1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // MB3: restarts at idx 0 with new QPs
    start_mb(6'd20, 6'd22);
    send_blocks(24, -1, -1);
    wait_done();
    chk("sb_empty_mb3", 256'(exp_q.size()), 256'd0);
    chk("idle_end", 256'(busy_o), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
